branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the five-stage MIPS pipeline.
- Combines a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- An optional global history register (GHR) switches indexing from bimodal to gshare.
- Sits beside the IF-stage PC. It predicts the next PC in the same cycle the instruction is fetched, and is trained by the branch-resolution logic in stage 2 (ID). It also keeps saturating branch/mispredict statistics.

Parameters:
ENTRIES, 16, number of BTB/counter entries; power of two, >= 2; IDX_W = log2(ENTRIES)
ADDR_W, 32, PC and target width
CTR_W, 2, direction counter width (>= 1)
GHR_W, 0, global history bits; 0 = bimodal, 1..IDX_W = gshare
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lk_pc  in  ADDR_W  IF-stage PC to predict
lk_hit  out  1  BTB tag hit for lk_pc
lk_taken  out  1  predicted taken (hit AND counter MSB)
lk_target  out  ADDR_W  predicted target (0 when no hit)
lk_ghr  out  max(GHR_W,1)  GHR value used for this lookup; pipeline carries it to stage 2
upd_valid  in  1  resolved branch in stage 2 this cycle
upd_pc  in  ADDR_W  PC of resolved branch
upd_ghr  in  max(GHR_W,1)  lk_ghr captured at that branch's fetch
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual branch target
upd_mispred  in  1  pipeline detected wrong direction or target
stat_branches  out  STAT_W  resolved-branch count
stat_mispred  out  STAT_W  mispredict count

Behaviour:
- Reset (asynchronous, immediate):
  - All entries valid=0, tag=0, target=0, counter=WNT (01 for CTR_W=2; generally 0 followed by all ones).
  - GHR=0; both statistics counters = 0.
  - Outputs therefore go immediately to lk_hit=0, lk_taken=0, lk_target=0, lk_ghr=0.
- Index and tag:
  - idx(pc, g) = pc[IDX_W+1:2] XOR zero-extended g when GHR_W>0; otherwise pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2]. PC bits [1:0] are ignored.
- Lookup:
  - Purely combinational from lk_pc and the current GHR; zero latency.
  - No bypass of a same-cycle update: a lookup always sees pre-edge table contents.
- Update (at posedge clk when upd_valid=1), entry e = idx(upd_pc, upd_ghr):
  - Tag hit (valid and tag match): counter saturating +1 if taken, -1 if not taken (no wrap at 0 or max). Target overwritten only when taken.
  - Tag miss, taken: allocate/replace. valid=1, tag, target=upd_target, counter=WT (MSB=1, rest 0).
  - Tag miss, not taken: table unchanged.
  - GHR (GHR_W>0): GHR <= {GHR[GHR_W-2:0], upd_taken}. The GHR is non-speculative and updated only at resolution.
- Statistics:
  - stat_branches increments on each upd_valid.
  - stat_mispred increments on upd_valid & upd_mispred.
  - Both saturate at all ones and never wrap.
- Boundary conditions:
  - upd_valid=0: no state change; upd_mispred and the other upd_* inputs are ignored.
  - Back-to-back updates to the same entry apply in order, one per cycle.
  - Lookup and update to the same index in the same cycle: the lookup returns old data and the update takes effect at that edge.
  - Reset asserted mid-update: the update is discarded and reset values win.
  - Reset deasserts synchronously to clk at the integration level; the block itself needs no synchroniser.

Decomposition:
- Shared header bp_defs.v holds:
  - counter encoding constants (SNT/WNT/WT/ST for CTR_W=2);
  - an idx/tag extraction function;
  - the saturating +/-1 function.
- One sub-module is natural: bp_sat_counter (CTR_W-bit saturating up/down counter with async reset to WNT), instantiated once per entry.
- The statistics counters reuse the saturating function inline.

Test Plan:
1. Reset, lk_pc=0x40 -> lk_hit=0, lk_taken=0, lk_target=0, lk_ghr=0, stats=0.
2. upd pc=0x40 taken target=0x80, ghr=0 -> next cycle lk_pc=0x40 gives hit=1, taken=1, target=0x80, stat_branches=1.
3. Counter saturation on entry 0x40:
   - Two not-taken updates: ctr 10->01->00, taken=0, hit stays 1, target stays 0x80.
   - Then four taken updates: ctr reaches 11 and stays 11.
4. Aliasing (ENTRIES=16): 0x40 and 0x80 share index 0.
   - Taken update pc=0x80 target=0x100 -> lookup 0x40 hit=0; lookup 0x80 hit=1, target=0x100.
   - Not-taken update of unseen pc=0xC4 -> table unchanged.
5. gshare (GHR_W=4): updates taken, taken, not-taken -> lk_ghr=0110.
   - Lookup pc=0x40 reads entry 0 XOR 6 = entry 6.
   - An update carrying upd_ghr=6 trains entry 6.
6. Statistics and reset: STAT_W=4, 20 updates with upd_mispred=1 -> both stats=15 (saturated). Pull rst_n low mid-cycle with upd_valid=1 -> stats=0 and lk_hit=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, index/tag
// extraction and the saturating +/-1 step used by direction and stat counters.
package branch_predictor_pkg;

  // Helpers operate on 32-bit containers; callers size the result back down.
  localparam int MAX_W = 32;

  // Named encodings of the common 2-bit direction counter.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr2_e;

  // Weakly-not-taken: 0 followed by all ones.
  function automatic logic [MAX_W-1:0] ctr_wnt(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Weakly-taken: MSB set, rest clear.
  function automatic logic [MAX_W-1:0] ctr_wt(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // Saturating +1 / -1 on a width-bit value; never wraps at 0 or all ones.
  function automatic logic [MAX_W-1:0] sat_step(input logic [MAX_W-1:0] val,
                                                input logic             up,
                                                input int               width);
    logic [MAX_W-1:0] max_val;
    max_val = (width >= MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
    if (up) return (val == max_val) ? val : val + 32'd1;
    else    return (val == '0)      ? val : val - 32'd1;
  endfunction

  // Word-aligned PC bits XOR (zero-extended) history, masked to idx_w bits.
  function automatic logic [MAX_W-1:0] bp_index(input logic [MAX_W-1:0] pc,
                                                input logic [MAX_W-1:0] ghr,
                                                input int               idx_w);
    return ((pc >> 2) ^ ghr) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [MAX_W-1:0] bp_tag(input logic [MAX_W-1:0] pc,
                                              input int               idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Per-entry saturating up/down direction counter; resets to weakly-not-taken
// and can be loaded to weakly-taken when its BTB entry is (re)allocated.
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  output logic [CTR_W-1:0] count
);

  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));
  localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= WNT;
    else if (load) count <= WT;
    else if (en)   count <= CTR_W'(sat_step(32'(count), up, CTR_W));
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters and optional gshare
// history; zero-latency lookup for IF, trained at branch resolution in ID.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int STAT_W  = 16,
  localparam int GW     = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  output logic [GW-1:0]     lk_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [GW-1:0]     upd_ghr,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0]            valid_q;
  logic [TAG_W-1:0]              tag_q    [ENTRIES];
  logic [ADDR_W-1:0]             target_q [ENTRIES];
  logic [ENTRIES-1:0][CTR_W-1:0] ctr;
  logic [GW-1:0]                 ghr_q;
  logic [STAT_W-1:0]             branches_q;
  logic [STAT_W-1:0]             mispred_q;

  logic [MAX_W-1:0] lk_g, upd_g;
  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, alloc, train;

  // History only participates in indexing when gshare is configured.
  assign lk_g  = (GHR_W > 0) ? 32'(ghr_q)   : '0;
  assign upd_g = (GHR_W > 0) ? 32'(upd_ghr) : '0;

  assign lk_idx  = IDX_W'(bp_index(32'(lk_pc), lk_g, IDX_W));
  assign lk_tag  = TAG_W'(bp_tag(32'(lk_pc), IDX_W));
  assign upd_idx = IDX_W'(bp_index(32'(upd_pc), upd_g, IDX_W));
  assign upd_tag = TAG_W'(bp_tag(32'(upd_pc), IDX_W));

  // Lookup reads pre-edge contents; a same-cycle update is not bypassed.
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr[lk_idx][CTR_W-1];
  assign lk_target = lk_hit ? target_q[lk_idx] : '0;
  assign lk_ghr    = ghr_q;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign train   = upd_valid && upd_hit;
  assign alloc   = upd_valid && !upd_hit && upd_taken;

  // NOTE: the table sits in flops, so it is cleared on reset; a RAM-based
  // table would instead need valid bits alone cleared (or a scrub sequence).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (alloc) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end else if (train && upd_taken) begin
      target_q[upd_idx] <= upd_target;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (train && (upd_idx == IDX_W'(i))),
      .up    (upd_taken),
      .load  (alloc && (upd_idx == IDX_W'(i))),
      .count (ctr[i])
    );
  end

  // Non-speculative history: shifted only when a branch resolves.
  if (GHR_W == 0) begin : g_no_ghr
    assign ghr_q = '0;
  end else if (GHR_W == 1) begin : g_ghr1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ghr_q <= '0;
      else if (upd_valid) ghr_q <= upd_taken;
    end
  end else begin : g_ghrn
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ghr_q <= '0;
      else if (upd_valid) ghr_q <= {ghr_q[GW-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else if (upd_valid) begin
      branches_q <= STAT_W'(sat_step(32'(branches_q), 1'b1, STAT_W));
      if (upd_mispred)
        mispred_q <= STAT_W'(sat_step(32'(mispred_q), 1'b1, STAT_W));
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;

endmodule
